// File: rtl/motion_pkg.sv
// Shared types and arithmetic helpers for the multi-object motion engine.
// Holds default widths, the per-channel state encoding, and width-generic
// sign-extension and saturating-add helpers used by motion_channel.
package motion_pkg;

    localparam int POS_W_DEF = 10;
    localparam int VEL_W_DEF = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FLY  = 1'b1
    } ch_state_t;

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic signed [31:0] sext(input logic [31:0] v, input int w);
        logic [31:0] sh;
        sh = v << (32 - w);
        return $signed(sh) >>> (32 - w);
    endfunction

    // Add two w-bit signed values, clamping to the symmetric range
    // [-(2^(w-1)-1), +(2^(w-1)-1)] so the result can always be negated.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int w);
        logic signed [31:0] s;
        logic signed [31:0] lim;
        s   = a + b;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (s > lim) begin
            return lim;
        end
        if (s < -lim) begin
            return -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/object_motion_array_if.sv
// Launch bus from the spawner into the motion array: one channel load
// request per cycle with its initial position, velocity and acceleration.
interface object_motion_array_if #(
    parameter int POS_W = 10,
    parameter int VEL_W = 10,
    parameter int IDX_W = 2
);
    logic             launch;
    logic [IDX_W-1:0] launch_idx;
    logic [POS_W-1:0] init_x;
    logic [POS_W-1:0] init_y;
    logic [VEL_W-1:0] init_vx;
    logic [VEL_W-1:0] init_vy;
    logic [VEL_W-1:0] init_ay;

    modport master (
        output launch, launch_idx, init_x, init_y, init_vx, init_vy, init_ay
    );

    modport slave (
        input launch, launch_idx, init_x, init_y, init_vx, init_vy, init_ay
    );
endinterface

// File: rtl/motion_channel.sv
// One object channel: position/velocity/acceleration registers, IDLE/FLY
// state and the retire (oob) pulse.
// Build option OBJECT_MOTION_BOUNCE_X_EN: objects reflect off the left and
// right walls instead of retiring on the x axis.
module motion_channel
    import motion_pkg::*;
#(
    parameter int POS_W = POS_W_DEF,
    parameter int VEL_W = VEL_W_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             move_tick,
    input  logic             acc_tick,
    input  logic             freeze,
    input  logic [POS_W-1:0] width,
    input  logic [POS_W-1:0] height,
    input  logic             load,
    input  logic [POS_W-1:0] init_x,
    input  logic [POS_W-1:0] init_y,
    input  logic [VEL_W-1:0] init_vx,
    input  logic [VEL_W-1:0] init_vy,
    input  logic [VEL_W-1:0] init_ay,
    output logic [POS_W-1:0] posx,
    output logic [POS_W-1:0] posy,
    output logic             active,
    output logic             oob
);
    // Two guard bits cover pos + velocity overflow in both directions.
    localparam int CW = POS_W + 2;
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_FLY  = FLY;
    localparam logic signed [CW-1:0] ONE = 1;

    logic [0:0]       state_reg;
    logic [POS_W-1:0] posx_reg, posy_reg;
    logic [VEL_W-1:0] vx_reg, vy_reg, ay_reg;
    logic             oob_reg;

    logic signed [CW-1:0] nx, ny, wid_s, hgt_s;
    logic [POS_W-1:0]     posx_next;
    logic [VEL_W-1:0]     vy_sum;
    logic                 x_out, y_out, y_clamp, retire, vy_pos;
`ifdef OBJECT_MOTION_BOUNCE_X_EN
    logic signed [CW-1:0] bx_hi, bx_lo;
`endif

    // Candidate next position, exit conditions and saturated velocity.
    always_comb begin
        wid_s   = $signed({2'b00, width});
        hgt_s   = $signed({2'b00, height});
        nx      = $signed({2'b00, posx_reg}) + CW'(sext(32'(vx_reg), VEL_W));
        ny      = $signed({2'b00, posy_reg}) + CW'(sext(32'(vy_reg), VEL_W));
        vy_pos  = !vy_reg[VEL_W-1] && (vy_reg != '0);
        x_out   = (nx < 0) || (nx >= wid_s);
        y_out   = (ny >= hgt_s) && vy_pos;
        y_clamp = (ny < 0);
        vy_sum  = VEL_W'(sat_add(sext(32'(vy_reg), VEL_W),
                                 sext(32'(ay_reg), VEL_W), VEL_W));
`ifdef OBJECT_MOTION_BOUNCE_X_EN
        bx_hi     = ((wid_s - ONE) <<< 1) - nx;
        bx_lo     = -nx;
        retire    = y_out;
        if (nx >= wid_s) begin
            posx_next = bx_hi[POS_W-1:0];
        end else if (nx < 0) begin
            posx_next = bx_lo[POS_W-1:0];
        end else begin
            posx_next = nx[POS_W-1:0];
        end
`else
        retire    = x_out || y_out;
        posx_next = nx[POS_W-1:0];
`endif
    end

    // Channel state: launch loads, ticks integrate while flying and unfrozen.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            posx_reg  <= '0;
            posy_reg  <= '0;
            vx_reg    <= '0;
            vy_reg    <= '0;
            ay_reg    <= '0;
            oob_reg   <= 1'b0;
        end else begin
            oob_reg <= 1'b0;
            if (load) begin
                // Launch wins over any tick; restarting a flying object is silent.
                state_reg <= ST_FLY;
                posx_reg  <= init_x;
                posy_reg  <= init_y;
                vx_reg    <= init_vx;
                vy_reg    <= init_vy;
                ay_reg    <= init_ay;
            end else if (state_reg == ST_FLY && !freeze) begin
                if (acc_tick) begin
                    vy_reg <= vy_sum;
                end
                if (move_tick) begin
                    if (retire) begin
                        state_reg <= ST_IDLE;
                        oob_reg   <= 1'b1;
                    end else begin
                        posx_reg <= posx_next;
`ifdef OBJECT_MOTION_BOUNCE_X_EN
                        if (x_out) begin
                            vx_reg <= -vx_reg;
                        end
`endif
                        if (y_clamp) begin
                            // Ceiling hit kills vertical speed, overriding any acc tick.
                            posy_reg <= '0;
                            vy_reg   <= '0;
                        end else begin
                            posy_reg <= ny[POS_W-1:0];
                        end
                    end
                end
            end
        end
    end

    assign posx   = posx_reg;
    assign posy   = posy_reg;
    assign active = (state_reg == ST_FLY);
    assign oob    = oob_reg;

endmodule

// File: rtl/object_motion_array.sv
// Multi-object motion engine: N_OBJ independent channels driven by
// edge-detected slow move/acc clocks, loaded from the spawner launch bus.
// Build option OBJECT_MOTION_BOUNCE_X_EN selects x-axis wall bounce in
// every channel instead of retiring objects that leave sideways.
module object_motion_array
    import motion_pkg::*;
#(
    parameter int N_OBJ = 4,
    parameter int POS_W = POS_W_DEF,
    parameter int VEL_W = VEL_W_DEF,
    parameter int IDX_W = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   moveclk,
    input  logic                   accclk,
    input  logic                   freeze,
    input  logic [POS_W-1:0]       width,
    input  logic [POS_W-1:0]       height,
    object_motion_array_if.slave   lb,
    output logic [N_OBJ*POS_W-1:0] posx,
    output logic [N_OBJ*POS_W-1:0] posy,
    output logic [N_OBJ-1:0]       active,
    output logic [N_OBJ-1:0]       oob
);
    logic [1:0]       mov_smp_reg;
    logic [1:0]       acc_smp_reg;
    logic             move_tick, acc_tick;
    logic [N_OBJ-1:0] load;

    // Shift samplers on the slow clocks; oldest sample in bit 1.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mov_smp_reg <= 2'b00;
            acc_smp_reg <= 2'b00;
        end else begin
            mov_smp_reg <= {mov_smp_reg[0], moveclk};
            acc_smp_reg <= {acc_smp_reg[0], accclk};
        end
    end

    assign move_tick = (mov_smp_reg == 2'b01);
    assign acc_tick  = (acc_smp_reg == 2'b01);

    genvar gi;
    generate
        for (gi = 0; gi < N_OBJ; gi++) begin : g_ch
            // Out-of-range indices match no channel and are dropped.
            assign load[gi] = lb.launch && (int'(lb.launch_idx) == gi);

            motion_channel #(
                .POS_W (POS_W),
                .VEL_W (VEL_W)
            ) u_ch (
                .clk       (clk),
                .rstn      (rstn),
                .move_tick (move_tick),
                .acc_tick  (acc_tick),
                .freeze    (freeze),
                .width     (width),
                .height    (height),
                .load      (load[gi]),
                .init_x    (lb.init_x),
                .init_y    (lb.init_y),
                .init_vx   (lb.init_vx),
                .init_vy   (lb.init_vy),
                .init_ay   (lb.init_ay),
                .posx      (posx[gi*POS_W +: POS_W]),
                .posy      (posy[gi*POS_W +: POS_W]),
                .active    (active[gi]),
                .oob       (oob[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_object_motion_array.sv
// Self-checking bench for object_motion_array: directed scenarios with
// hand-computed expectations plus a randomized run against a plain
// integer model of the motion rules.
module tb_object_motion_array;
    localparam int N = 4;
    localparam int PW = 10;
    localparam int VW = 10;

    logic clk = 1'b0;
    logic rstn, moveclk, accclk, freeze;
    logic [PW-1:0] width, height;
    logic [N*PW-1:0] posx, posy;
    logic [N-1:0] active, oob;

    int checks = 0;
    int errors = 0;

    object_motion_array_if #(.POS_W(PW), .VEL_W(VW), .IDX_W(2)) lb ();

    object_motion_array #(.N_OBJ(N), .POS_W(PW), .VEL_W(VW), .IDX_W(2)) dut (
        .clk(clk), .rstn(rstn), .moveclk(moveclk), .accclk(accclk), .freeze(freeze),
        .width(width), .height(height), .lb(lb),
        .posx(posx), .posy(posy), .active(active), .oob(oob)
    );

    always #5 clk = ~clk;

    // Reference model state: plain integers per object.
    int m_px[N], m_py[N], m_vx[N], m_vy[N], m_ay[N];
    bit m_act[N], m_oob[N];
    bit mv_h1, mv_h2, ac_h1, ac_h2;   // last two sampled slow-clock levels

    function automatic int sat(input int v);
        if (v > 511) return 511;
        if (v < -511) return -511;
        return v;
    endfunction

    // Apply one clk edge of the motion rules to the model.
    function automatic void model_edge();
        bit mt, at;
        if (!rstn) begin
            for (int c = 0; c < N; c++) begin
                m_px[c] = 0; m_py[c] = 0; m_vx[c] = 0; m_vy[c] = 0; m_ay[c] = 0;
                m_act[c] = 0; m_oob[c] = 0;
            end
            mv_h1 = 0; mv_h2 = 0; ac_h1 = 0; ac_h2 = 0;
            return;
        end
        mt = mv_h1 && !mv_h2 && !freeze;
        at = ac_h1 && !ac_h2 && !freeze;
        for (int c = 0; c < N; c++) begin
            m_oob[c] = 0;
            if (lb.launch && int'(lb.launch_idx) == c) begin
                m_act[c] = 1;
                m_px[c] = int'(lb.init_x);
                m_py[c] = int'(lb.init_y);
                m_vx[c] = int'($signed(lb.init_vx));
                m_vy[c] = int'($signed(lb.init_vy));
                m_ay[c] = int'($signed(lb.init_ay));
            end else if (m_act[c]) begin
                int nx, ny, old_vy, W, H;
                bit gone, xo;
                W = int'(width); H = int'(height);
                old_vy = m_vy[c];
                gone = 0;
                if (at) m_vy[c] = sat(old_vy + m_ay[c]);
                if (mt) begin
                    nx = m_px[c] + m_vx[c];
                    ny = m_py[c] + old_vy;
                    xo = (nx < 0) || (nx >= W);
`ifdef OBJECT_MOTION_BOUNCE_X_EN
                    gone = (ny >= H) && (old_vy > 0);
`else
                    gone = xo || ((ny >= H) && (old_vy > 0));
`endif
                    if (gone) begin
                        m_act[c] = 0;
                        m_oob[c] = 1;
                    end else begin
`ifdef OBJECT_MOTION_BOUNCE_X_EN
                        if (nx >= W) begin
                            m_px[c] = 2 * (W - 1) - nx; m_vx[c] = -m_vx[c];
                        end else if (nx < 0) begin
                            m_px[c] = -nx; m_vx[c] = -m_vx[c];
                        end else begin
                            m_px[c] = nx;
                        end
`else
                        m_px[c] = nx;
`endif
                        if (ny < 0) begin
                            m_py[c] = 0; m_vy[c] = 0;
                        end else begin
                            m_py[c] = ny;
                        end
                    end
                end
            end
        end
        mv_h2 = mv_h1; mv_h1 = moveclk;
        ac_h2 = ac_h1; ac_h1 = accclk;
    endfunction

    function automatic logic [N*PW-1:0] exp_px();
        logic [N*PW-1:0] v;
        for (int c = 0; c < N; c++) v[c*PW +: PW] = PW'(m_px[c]);
        return v;
    endfunction

    function automatic logic [N*PW-1:0] exp_py();
        logic [N*PW-1:0] v;
        for (int c = 0; c < N; c++) v[c*PW +: PW] = PW'(m_py[c]);
        return v;
    endfunction

    function automatic logic [N-1:0] exp_act();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = m_act[c];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_oob();
        logic [N-1:0] v;
        for (int c = 0; c < N; c++) v[c] = m_oob[c];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic move_tick();
        moveclk = 1'b1; step(); moveclk = 1'b0; step();
    endtask

    task automatic acc_tick();
        accclk = 1'b1; step(); accclk = 1'b0; step();
    endtask

    task automatic set_launch(input int c, input int x, input int y,
                              input int vx, input int vy, input int ay);
        lb.launch = 1'b1;
        lb.launch_idx = 2'(c);
        lb.init_x = PW'(x); lb.init_y = PW'(y);
        lb.init_vx = VW'(vx); lb.init_vy = VW'(vy); lb.init_ay = VW'(ay);
    endtask

    task automatic launch_ch(input int c, input int x, input int y,
                             input int vx, input int vy, input int ay);
        set_launch(c, x, y, vx, vy, ay);
        step();
        lb.launch = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; step(); step(); rstn = 1'b1; step();
        checks++; if (active !== '0) begin errors++; $display("FAIL reset_active got=%h exp=0", active); end
        checks++; if (oob !== '0) begin errors++; $display("FAIL reset_oob got=%h exp=0", oob); end
        checks++; if (posx !== '0) begin errors++; $display("FAIL reset_posx got=%h exp=0", posx); end
        checks++; if (posy !== '0) begin errors++; $display("FAIL reset_posy got=%h exp=0", posy); end
        $display("reset: active=%h posx=%h posy=%h", active, posx, posy);
    endtask

    task automatic test_integration();
        width = 10'd640; height = 10'd480;
        launch_ch(0, 100, 470, 3, -8, 1);
        checks++; if (active[0] !== 1'b1) begin errors++; $display("FAIL launch_active0 got=%b exp=1", active[0]); end
        checks++; if (posx[9:0] !== 10'd100 || posy[9:0] !== 10'd470) begin
            errors++; $display("FAIL launch_pos0 got=%0d,%0d exp=100,470", posx[9:0], posy[9:0]); end
        move_tick();
        checks++; if (posx[9:0] !== 10'd103 || posy[9:0] !== 10'd462) begin
            errors++; $display("FAIL move1_pos0 got=%0d,%0d exp=103,462", posx[9:0], posy[9:0]); end
        acc_tick();
        checks++; if (posy[9:0] !== 10'd462) begin errors++; $display("FAIL acc_hold_pos0 got=%0d exp=462", posy[9:0]); end
        move_tick();
        checks++; if (posx[9:0] !== 10'd106 || posy[9:0] !== 10'd455) begin
            errors++; $display("FAIL move2_pos0 got=%0d,%0d exp=106,455", posx[9:0], posy[9:0]); end
        $display("integration: ch0 pos=%0d,%0d", posx[9:0], posy[9:0]);
    endtask

    task automatic test_x_exit();
        launch_ch(1, 638, 100, 3, 0, 0);
        move_tick();
`ifdef OBJECT_MOTION_BOUNCE_X_EN
        checks++; if (oob[1] !== 1'b0) begin errors++; $display("FAIL bounce_no_oob got=%b exp=0", oob[1]); end
        checks++; if (posx[19:10] !== 10'd637 || active[1] !== 1'b1) begin
            errors++; $display("FAIL bounce_pos1 got=%0d act=%b exp=637 act=1", posx[19:10], active[1]); end
        move_tick();
        checks++; if (posx[19:10] !== 10'd634) begin errors++; $display("FAIL bounce_vx1 got=%0d exp=634", posx[19:10]); end
`else
        checks++; if (oob[1] !== 1'b1) begin errors++; $display("FAIL exit_oob_pulse got=%b exp=1", oob[1]); end
        checks++; if (active[1] !== 1'b0 || posx[19:10] !== 10'd638) begin
            errors++; $display("FAIL exit_state1 act=%b posx=%0d exp act=0 posx=638", active[1], posx[19:10]); end
        step();
        checks++; if (oob[1] !== 1'b0) begin errors++; $display("FAIL exit_oob_width got=%b exp=0", oob[1]); end
`endif
        $display("x_exit: ch1 posx=%0d active=%b oob=%b", posx[19:10], active[1], oob[1]);
    endtask

    task automatic test_saturation();
        height = 10'd1023;
        launch_ch(2, 10, 0, 0, 510, 5);
        launch_ch(3, 10, 1023, 0, -510, -5);
        acc_tick(); acc_tick();
        move_tick();
        checks++; if (posy[29:20] !== 10'd511) begin errors++; $display("FAIL sat_pos_1 got=%0d exp=511", posy[29:20]); end
        checks++; if (posy[39:30] !== 10'd512) begin errors++; $display("FAIL sat_neg_1 got=%0d exp=512", posy[39:30]); end
        move_tick();
        checks++; if (posy[29:20] !== 10'd1022) begin errors++; $display("FAIL sat_pos_2 got=%0d exp=1022", posy[29:20]); end
        checks++; if (posy[39:30] !== 10'd1) begin errors++; $display("FAIL sat_neg_2 got=%0d exp=1", posy[39:30]); end
        $display("saturation: ch2 posy=%0d ch3 posy=%0d", posy[29:20], posy[39:30]);
    endtask

    task automatic test_launch_priority();
        moveclk = 1'b1; step(); moveclk = 1'b0;
        set_launch(2, 200, 300, 5, -4, 2);
        step();
        lb.launch = 1'b0;
        checks++; if (posx[29:20] !== 10'd200 || posy[29:20] !== 10'd300) begin
            errors++; $display("FAIL prio_load2 got=%0d,%0d exp=200,300", posx[29:20], posy[29:20]); end
        checks++; if (posy[39:30] !== 10'd0 || posx[39:30] !== 10'd10) begin
            errors++; $display("FAIL prio_ceiling3 got=%0d,%0d exp=10,0", posx[39:30], posy[39:30]); end
        checks++; if (posx !== exp_px() || posy !== exp_py()) begin
            errors++; $display("FAIL prio_others got=%h/%h exp=%h/%h", posx, posy, exp_px(), exp_py()); end
        move_tick();
        checks++; if (posx[29:20] !== 10'd205 || posy[29:20] !== 10'd296) begin
            errors++; $display("FAIL prio_step2 got=%0d,%0d exp=205,296", posx[29:20], posy[29:20]); end
        $display("launch_priority: ch2 pos=%0d,%0d", posx[29:20], posy[29:20]);
    endtask

    task automatic test_freeze_reset();
        logic [N*PW-1:0] sx, sy;
        sx = exp_px(); sy = exp_py();
        freeze = 1'b1;
        repeat (3) move_tick();
        acc_tick();
        freeze = 1'b0;
        step();
        checks++; if (posx !== sx || posy !== sy) begin
            errors++; $display("FAIL freeze_hold got=%h/%h exp=%h/%h", posx, posy, sx, sy); end
        checks++; if (active !== exp_act()) begin errors++; $display("FAIL pre_reset_active got=%h exp=%h", active, exp_act()); end
        rstn = 1'b0; step();
        checks++; if (active !== '0 || oob !== '0) begin
            errors++; $display("FAIL midreset_flags act=%h oob=%h exp=0,0", active, oob); end
        checks++; if (posx !== '0 || posy !== '0) begin
            errors++; $display("FAIL midreset_pos got=%h/%h exp=0", posx, posy); end
        rstn = 1'b1; step();
        checks++; if (oob !== '0 || active !== '0) begin
            errors++; $display("FAIL postreset got act=%h oob=%h exp=0,0", active, oob); end
        $display("freeze_reset: active=%h posx=%h", active, posx);
    endtask

    task automatic test_random();
        int errs0;
        errs0 = errors;
        width = 10'd640; height = 10'd480;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) moveclk = ~moveclk;
            if ($urandom_range(5) == 0) accclk = ~accclk;
            freeze = ($urandom_range(9) == 0);
            if ($urandom_range(2) == 0)
                set_launch(int'($urandom_range(3)), int'($urandom_range(639)), int'($urandom_range(479)),
                           int'($urandom_range(40)) - 20, int'($urandom_range(60)) - 30,
                           int'($urandom_range(6)) - 3);
            else
                lb.launch = 1'b0;
            step();
            checks++; if (posx !== exp_px()) begin errors++; $display("FAIL rand_posx cyc=%0d got=%h exp=%h", i, posx, exp_px()); end
            checks++; if (posy !== exp_py()) begin errors++; $display("FAIL rand_posy cyc=%0d got=%h exp=%h", i, posy, exp_py()); end
            checks++; if (active !== exp_act()) begin errors++; $display("FAIL rand_active cyc=%0d got=%h exp=%h", i, active, exp_act()); end
            checks++; if (oob !== exp_oob()) begin errors++; $display("FAIL rand_oob cyc=%0d got=%h exp=%h", i, oob, exp_oob()); end
        end
        lb.launch = 1'b0; freeze = 1'b0;
        $display("random: 600 cycles, %0d new errors", errors - errs0);
    endtask

    initial begin
        rstn = 1'b0; moveclk = 1'b0; accclk = 1'b0; freeze = 1'b0;
        width = 10'd640; height = 10'd480;
        lb.launch = 1'b0; lb.launch_idx = '0;
        lb.init_x = '0; lb.init_y = '0; lb.init_vx = '0; lb.init_vy = '0; lb.init_ay = '0;
        test_reset();
        test_integration();
        test_x_exit();
        test_saturation();
        test_launch_priority();
        test_freeze_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/object_motion_array.md
Name: object_motion_array

Overview:
- Parametrised multi-object motion engine; successor to the two-object motion block.
- Holds up to N_OBJ independent objects (fruits/bombs), each with position, signed velocity and signed vertical acceleration.
- Integrates velocity on `moveclk` ticks and acceleration on `accclk` ticks, and retires objects that leave the play field with a one-cycle `oob` pulse.
- Sits between the spawner (launch side) and the renderer/slice-detector (position readers).

Parameters:
- N_OBJ, 4, number of object channels
- POS_W, 10, position width (unsigned pixels)
- VEL_W, 10, velocity and acceleration width (two's complement)
- IDX_W, 2, launch index width, must be at least clog2(N_OBJ)

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, synchronous, active-low
- moveclk  in  1  slow position-step clock, treated as data and edge-detected
- accclk  in  1  slow velocity-step clock, treated as data and edge-detected
- freeze  in  1  pause; ticks are ignored while high
- width  in  POS_W  play-field width
- height  in  POS_W  play-field height
- launch  in  1  load one channel this cycle
- launch_idx  in  IDX_W  channel to load
- init_x, init_y  in  POS_W  launch position
- init_vx, init_vy  in  VEL_W  launch velocity, signed
- init_ay  in  VEL_W  vertical acceleration, signed; positive means downward
- posx, posy  out  N_OBJ*POS_W  flattened positions; channel i is at bits [i*POS_W +: POS_W]
- active  out  N_OBJ  channel in flight
- oob  out  N_OBJ  one-cycle pulse when a channel leaves the field

Behaviour:
- Reset (rstn low at a clk edge):
  - all pos, vel and acc registers = 0; active = 0; oob = 0; tick samplers = 00.
  - Applies mid-flight too; no pulse is generated.
- Tick detection: 2-bit shift sampler per slow clock; the tick is high for exactly one clk when the sampler holds 01.
  - Registers update on the edge where the tick is high.
  - Outputs therefore change on the 2nd clk edge after the slow clock is first sampled high.
- Per-channel states: IDLE and FLY.
- IDLE:
  - Launch to this channel → FLY, loading init values; takes effect at the next edge.
  - Ticks are ignored; pos holds its last value.
- FLY, on a move tick with freeze low:
  - nx = posx + sext(vx) and ny = posy + sext(vy), computed in POS_W+2-bit signed.
  - nx < 0 or nx >= width → oob: posx/posy hold, active clears, the oob bit pulses 1 cycle, state → IDLE.
  - ny >= height with vy > 0 → oob, same handling.
  - ny < 0 → posy = 0 and vy = 0 (ceiling clamp), not oob.
  - Otherwise pos = nx, ny.
- FLY, on an acc tick with freeze low:
  - vy = vy + ay, saturating to [-(2^(VEL_W-1)-1), +(2^(VEL_W-1)-1)].
  - vx is unchanged.
- Move and acc tick in the same cycle: position uses the old vy; vy updates concurrently.
- Launch to a FLY channel: restart with the new values; no oob pulse.
- Launch and tick to the same channel in the same cycle: launch wins; the loaded values are not stepped.
- Launch with launch_idx >= N_OBJ: ignored.
- Only one launch per cycle.
- Multiple channels may pulse oob in the same cycle.
- Ticks that arrive while freeze is high are dropped, not queued.

Optional Feature:
- Macro: OBJECT_MOTION_BOUNCE_X_EN.
- Defined:
  - nx >= width → posx = 2*(width-1) - nx and vx = -vx.
  - nx < 0 → posx = -nx and vx = -vx.
  - No oob on the x-axis; the y rules are unchanged.
- Undefined: x-axis exit retires the object as above.

Decomposition:
- Package motion_pkg: POS_W/VEL_W defaults, channel state enum {IDLE, FLY}, saturating-add function, sign-extend helper.
- Sub-module motion_channel: one object's registers, state and oob logic.
  - Instantiated N_OBJ times by generate.
  - The top owns the tick samplers and the launch decode.

Test Plan:
- Integration: N_OBJ=4, width=640, height=480; launch ch0 with x=100, y=470, vx=+3, vy=-8, ay=+1 → after 1 move tick posx0=103, posy0=462; after 1 acc tick vy=-7; next move tick posy0=455.
- x-axis exit: launch ch1 with x=638, vx=+3, vy=0 → on the move tick oob[1] is high for exactly 1 cycle, active[1]=0, posx1 stays 638. With OBJECT_MOTION_BOUNCE_X_EN → posx1=637, vx=-3, no oob.
- Velocity saturation: VEL_W=10, vy=+510, ay=+5 → after an acc tick vy=+511; a further tick leaves it at +511. Similarly vy=-510, ay=-5 → -511.
- Launch priority: launch to ch2 coincident with a move tick → ch2 holds exactly the init values next cycle, and the other channels step normally.
- Freeze and reset: freeze=1 across 3 move ticks → all positions unchanged. Then rstn=0 for 1 cycle mid-flight → active=0, posx=posy=0, oob stays 0.
